// File: rtl/turbosound_bus_arbiter.sv
// rtl/turbosound_bus_arbiter.sv - shares the AY/YM register bus between the CPU and the player engine
module turbosound_bus_arbiter #(
   parameter int STROBE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       disable_ay,
   input  logic       disable_turboay,
   input  logic       cpu_bdir,
   input  logic       cpu_bc1,
   input  logic [7:0] cpu_din,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_chip,
   input  logic [3:0] req_reg,
   input  logic [7:0] req_data,
   output logic       req_drop,
   output logic       busy,
   output logic       bdir,
   output logic       bc1,
   output logic [7:0] dout
);

   localparam int            CW       = $clog2(STROBE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYCLES);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEL   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_RADDR = 3'd4;
   localparam logic [2:0] S_RSEL  = 3'd5;

   logic [2:0]    state;
   logic [CW-1:0] cnt;        // 0..STROBE_CYCLES-1 strobe, STROBE_CYCLES is the gap / step end
   logic          held;       // CPU preempted the current step; state and cnt are frozen
   logic          cpu_sel;    // chip the software believes is selected
   logic          cur_sel;    // chip the hardware actually has selected
   logic [7:0]    cpu_addr [0:1];
   logic          chip_q;
   logic [3:0]    reg_q;
   logic [7:0]    data_q;
   logic [7:0]    raddr_q;

   logic          cpu_active;
   logic          cpu_wr_addr;
   logic          accept;
   logic          drop_req;
   logic          step_end;
   logic          strobe;
   logic [2:0]    next_step;
   logic [2:0]    restart_state;
   logic [7:0]    p_val;

   assign cpu_active  = cpu_bdir | cpu_bc1;
   assign cpu_wr_addr = cpu_bdir & cpu_bc1;
   assign req_ready   = (state == S_IDLE) & ~cpu_active & ~reset;
   assign accept      = req_valid & req_ready;
   assign drop_req    = disable_ay | (~req_chip & disable_turboay);
   assign busy        = (state != S_IDLE);
   assign step_end    = busy & ~held & (cnt == CNT_LAST);
   assign strobe      = busy & ~held & (cnt != CNT_LAST);

   // Step sequencing and the restart point after a CPU preemption
   always_comb begin
      next_step     = S_IDLE;
      restart_state = S_RADDR;
      case (state)
         S_SEL:   next_step = S_ADDR;
         S_ADDR:  next_step = S_DATA;
         S_DATA:  next_step = S_RADDR;
         S_RADDR: next_step = (cur_sel != cpu_sel) ? S_RSEL : S_IDLE;
         default: next_step = S_IDLE;
      endcase
      if (state == S_SEL || state == S_ADDR || state == S_DATA)
         restart_state = (chip_q != cur_sel) ? S_SEL : S_ADDR;
   end

   // Player state machine: accept/drop, strobe counting, preemption freeze and restart
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         held     <= 1'b0;
         req_drop <= 1'b0;
         chip_q   <= 1'b0;
         reg_q    <= 4'h0;
         data_q   <= 8'h00;
         raddr_q  <= 8'h00;
      end else begin
         req_drop <= 1'b0;
         if (state == S_IDLE) begin
            if (accept) begin
               chip_q <= req_chip;
               reg_q  <= req_reg;
               data_q <= req_data;
               cnt    <= '0;
               if (drop_req)
                  req_drop <= 1'b1;
               else
                  state <= (req_chip != cur_sel) ? S_SEL : S_ADDR;
            end
         end else if (held) begin
            if (!cpu_active) begin
               held  <= 1'b0;
               state <= restart_state;
               cnt   <= '0;
               if (restart_state == S_RADDR)
                  raddr_q <= cpu_addr[chip_q];
            end
         end else if (cnt == CNT_LAST) begin
            // a CPU access on the step-end cycle preempts the step that follows
            state <= next_step;
            cnt   <= '0;
            held  <= cpu_active & (next_step != S_IDLE);
            if (next_step == S_RADDR)
               raddr_q <= cpu_addr[chip_q];
         end else if (cpu_active) begin
            held <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // CPU bus snooping plus chip-select bookkeeping for player SEL/RSEL steps
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_sel     <= 1'b1;
         cur_sel     <= 1'b1;
         cpu_addr[0] <= 8'h00;
         cpu_addr[1] <= 8'h00;
      end else begin
         if (step_end && state == S_SEL)
            cur_sel <= chip_q;
         else if (step_end && state == S_RSEL)
            cur_sel <= cpu_sel;
         // a CPU select on the same cycle is what the chips see last, so it wins
         if (cpu_wr_addr) begin
            if (cpu_din[7:1] == 7'h7F && !disable_ay && !disable_turboay) begin
               cpu_sel <= cpu_din[0];
               cur_sel <= cpu_din[0];
            end else if (!disable_ay) begin
               cpu_addr[cpu_sel] <= cpu_din;
            end
         end
      end
   end

   // Bus output: CPU passes straight through, otherwise the player strobe decoded from state
   always_comb begin
      case (state)
         S_SEL:   p_val = {7'h7F, chip_q};
         S_ADDR:  p_val = {4'h0, reg_q};
         S_DATA:  p_val = data_q;
         S_RADDR: p_val = raddr_q;
         S_RSEL:  p_val = {7'h7F, cpu_sel};
         default: p_val = 8'h00;
      endcase
      if (cpu_active) begin
         bdir = cpu_bdir;
         bc1  = cpu_bc1;
         dout = cpu_din;
      end else begin
         bdir = strobe;
         bc1  = strobe & (state != S_DATA);
         dout = strobe ? p_val : 8'h00;
      end
   end

endmodule

// File: tb/tb_turbosound_bus_arbiter.sv
// tb/tb_turbosound_bus_arbiter.sv - directed self-checking bench for turbosound_bus_arbiter
module tb_turbosound_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       disable_ay = 1'b0;
   logic       disable_turboay = 1'b0;
   logic       cpu_bdir = 1'b0;
   logic       cpu_bc1 = 1'b0;
   logic [7:0] cpu_din = 8'h00;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_chip = 1'b0;
   logic [3:0] req_reg = 4'h0;
   logic [7:0] req_data = 8'h00;
   logic       req_drop;
   logic       busy;
   logic       bdir;
   logic       bc1;
   logic [7:0] dout;

   int errors = 0;
   int checks = 0;

   // strobe capture: each segment is {bc1, dout} plus its length in cycles
   logic       cap_en = 1'b0;
   logic [8:0] seg_val [0:15];
   int         seg_len [0:15];
   int         nseg;
   int         busy_cnt;
   int         gap_cnt;
   logic       prev_on;
   logic [8:0] prev_val;
   logic       cpu_on;

   assign cpu_on = cpu_bdir | cpu_bc1;

   turbosound_bus_arbiter #(.STROBE_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .disable_ay(disable_ay), .disable_turboay(disable_turboay),
      .cpu_bdir(cpu_bdir), .cpu_bc1(cpu_bc1), .cpu_din(cpu_din),
      .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
      .req_reg(req_reg), .req_data(req_data), .req_drop(req_drop), .busy(busy),
      .bdir(bdir), .bc1(bc1), .dout(dout)
   );

   always #5 clk = ~clk;

   // record player strobes on the falling edge, clearing whenever capture is off
   always @(negedge clk) begin
      if (!cap_en) begin
         nseg = 0;
         busy_cnt = 0;
         gap_cnt = 0;
         prev_on = 1'b0;
         prev_val = 9'h0;
      end else begin
         if (busy) busy_cnt++;
         if (busy && !bdir && !cpu_on) gap_cnt++;
         if (bdir && !cpu_on) begin
            if (!prev_on || prev_val != {bc1, dout}) begin
               if (nseg < 16) begin
                  seg_val[nseg] = {bc1, dout};
                  seg_len[nseg] = 1;
               end
               nseg++;
            end else if (nseg <= 16) begin
               seg_len[nseg-1]++;
            end
            prev_on = 1'b1;
            prev_val = {bc1, dout};
         end else begin
            prev_on = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      check(tag, {31'h0, busy}, 32'h0);
   endtask

   task automatic seg_is(input int i, input logic [8:0] v, input int len);
      check($sformatf("seg%0d_val", i), {23'h0, seg_val[i]}, {23'h0, v});
      check($sformatf("seg%0d_len", i), seg_len[i], len);
   endtask

   task automatic start_capture();
      cap_en = 1'b0;
      tick(1);
      cap_en = 1'b1;
   endtask

   task automatic run_req(input logic c, input logic [3:0] r, input logic [7:0] d);
      start_capture();
      req_chip = c;
      req_reg = r;
      req_data = d;
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      wait_idle("req_idle_timeout");
   endtask

   task automatic cpu_write(input logic [7:0] d);
      cpu_bdir = 1'b1;
      cpu_bc1 = 1'b1;
      cpu_din = d;
      tick(1);
      cpu_bdir = 1'b0;
      cpu_bc1 = 1'b0;
      tick(1);
   endtask

   initial begin
      // reset state
      tick(2);
      check("rst_bdir", {31'h0, bdir}, 0);
      check("rst_bc1", {31'h0, bc1}, 0);
      check("rst_dout", {24'h0, dout}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_ready", {31'h0, req_ready}, 0);
      check("rst_drop", {31'h0, req_drop}, 0);
      reset = 1'b0;
      tick(1);
      check("ready_after_rst", {31'h0, req_ready}, 1);

      // 1: plain write to the selected chip, no SEL/RSEL
      run_req(1'b1, 4'h7, 8'h38);
      check("t1_nseg", nseg, 3);
      seg_is(0, {1'b1, 8'h07}, 16);
      seg_is(1, {1'b0, 8'h38}, 16);
      seg_is(2, {1'b1, 8'h00}, 16);
      check("t1_busy_cycles", busy_cnt, 51);
      check("t1_gaps", gap_cnt, 3);

      // 2: CPU selects chip 2 and latches address 5, player writes chip 1
      cpu_bdir = 1'b1;
      cpu_bc1 = 1'b1;
      cpu_din = 8'hFE;
      #1;
      check("t2_pass_dout", {24'h0, dout}, 32'hFE);
      check("t2_pass_bc1", {31'h0, bc1}, 1);
      tick(1);
      cpu_bdir = 1'b0;
      cpu_bc1 = 1'b0;
      tick(1);
      cpu_write(8'h05);
      run_req(1'b1, 4'h8, 8'h0F);
      check("t2_nseg", nseg, 5);
      seg_is(0, {1'b1, 8'hFF}, 16);
      seg_is(1, {1'b1, 8'h08}, 16);
      seg_is(2, {1'b0, 8'h0F}, 16);
      seg_is(3, {1'b1, 8'h00}, 16);
      seg_is(4, {1'b1, 8'hFE}, 16);
      check("t2_busy_cycles", busy_cnt, 85);

      // 3: CPU preempts the DATA strobe; sequence restarts at ADDR
      start_capture();
      req_chip = 1'b0;
      req_reg = 4'h3;
      req_data = 8'hAA;
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(22);
      cpu_bdir = 1'b1;
      cpu_din = 8'h55;
      #1;
      check("t3_pass_bdir", {31'h0, bdir}, 1);
      check("t3_pass_bc1", {31'h0, bc1}, 0);
      check("t3_pass_dout", {24'h0, dout}, 32'h55);
      tick(3);
      check("t3_busy_held", {31'h0, busy}, 1);
      check("t3_ready_held", {31'h0, req_ready}, 0);
      cpu_bdir = 1'b0;
      cpu_din = 8'h00;
      wait_idle("t3_idle_timeout");
      check("t3_nseg", nseg, 5);
      seg_is(0, {1'b1, 8'h03}, 16);
      seg_is(1, {1'b0, 8'hAA}, 5);
      seg_is(2, {1'b1, 8'h03}, 16);
      seg_is(3, {1'b0, 8'hAA}, 16);
      seg_is(4, {1'b1, 8'h05}, 16);

      // 4: second chip disabled -> drop; select code becomes an address write
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      disable_turboay = 1'b1;
      start_capture();
      req_chip = 1'b0;
      req_reg = 4'h1;
      req_data = 8'h11;
      req_valid = 1'b1;
      #1;
      check("t4_ready", {31'h0, req_ready}, 1);
      tick(1);
      req_valid = 1'b0;
      check("t4_drop", {31'h0, req_drop}, 1);
      check("t4_busy", {31'h0, busy}, 0);
      tick(1);
      check("t4_drop_end", {31'h0, req_drop}, 0);
      check("t4_no_strobe", nseg, 0);
      cpu_write(8'hFE);
      disable_turboay = 1'b0;
      run_req(1'b1, 4'h2, 8'h22);
      check("t4_nseg", nseg, 3);
      seg_is(0, {1'b1, 8'h02}, 16);
      seg_is(2, {1'b1, 8'hFE}, 16);

      // 5: request waits while the CPU holds the bus
      cpu_bc1 = 1'b1;
      req_chip = 1'b1;
      req_reg = 4'h4;
      req_data = 8'h44;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check($sformatf("t5_ready_%0d", i), {31'h0, req_ready}, 0);
         check($sformatf("t5_busy_%0d", i), {31'h0, busy}, 0);
      end
      cpu_bc1 = 1'b0;
      #1;
      check("t5_ready_idle", {31'h0, req_ready}, 1);
      tick(1);
      req_valid = 1'b0;
      check("t5_accepted", {31'h0, busy}, 1);
      wait_idle("t5_idle_timeout");

      // 6: reset in the middle of RADDR
      start_capture();
      req_chip = 1'b1;
      req_reg = 4'h9;
      req_data = 8'h99;
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
      tick(40);
      check("t6_raddr_bc1", {31'h0, bc1}, 1);
      check("t6_raddr_dout", {24'h0, dout}, 32'hFE);
      reset = 1'b1;
      tick(1);
      check("t6_bdir", {31'h0, bdir}, 0);
      check("t6_bc1", {31'h0, bc1}, 0);
      check("t6_dout", {24'h0, dout}, 0);
      check("t6_busy", {31'h0, busy}, 0);
      reset = 1'b0;
      run_req(1'b1, 4'h1, 8'h01);
      check("t6_nseg", nseg, 3);
      seg_is(0, {1'b1, 8'h01}, 16);
      seg_is(2, {1'b1, 8'h00}, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
